// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at accept, held pending, and committed when the busy window ends.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        sdiv_q;
  logic [31:0]        sdiv_r;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign smul   = a_sx * b_sx;
  assign umul   = {32'd0, A} * {32'd0, B};
  assign sdiv_q = $signed(A) / $signed(B);
  assign sdiv_r = $signed(A) % $signed(B);

  // The most-negative / -1 case is pinned explicitly; a zero divisor suppresses the commit.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (MDUop)
      OP_MULT: begin
        {res_hi, res_lo} = smul;
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = umul;
        res_wr = 1'b1;
      end
      OP_DIV: begin
        if (B != 32'd0) begin
          res_wr = 1'b1;
          if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
          end else begin
            res_lo = sdiv_q;
            res_hi = sdiv_r;
          end
        end
      end
      OP_DIVU: begin
        if (B != 32'd0) begin
          res_wr = 1'b1;
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (MDUop)
              OP_MULT, OP_MULTU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
                counter <= CNT_W'(MULT_CYCLES);
                state   <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
                counter <= CNT_W'(DIV_CYCLES);
                state   <= ST_RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        default: begin
          // Any start during RUN, including on the completion edge, is dropped.
          if (counter == CNT_W'(1)) begin
            state   <= ST_IDLE;
            counter <= '0;
            if (pend_wr) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares each time busy falls.
module tb_md_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] len;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUop (MDUop),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit push, input string name,
                               input logic [31:0] eh, input logic [31:0] el, input int len);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    MDUop = op;
    A = a;
    B = b;
    if (push) begin
      e.name = name;
      e.hi = eh;
      e.lo = el;
      e.len = 32'(len);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    MDUop = OP_NONE;
  endtask

  task automatic pulseStart(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDUop = op;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    MDUop = OP_NONE;
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: busy=%b pending=%0d expected idle with empty scoreboard",
               name, busy, sb.size());
    end
  endtask

  // Monitor: a busy window ending without reset is one completed operation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_completion: got busy window of %0d expected none", busy_cnt);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_hi"}, HI, e.hi);
          checkOutput({e.name, "_lo"}, LO, e.lo);
          checkOutput({e.name, "_len"}, 32'(busy_cnt), e.len);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    MDUop = OP_NONE;
    A = 32'd0;
    B = 32'd0;
    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_hi", HI, 32'd0);
    checkOutput("rst_lo", LO, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;

    applyStimulus(OP_MTHI, 32'hAAAA_0001, 32'd0, 1'b0, "", 32'd0, 32'd0, 0);
    checkOutput("mthi_hi", HI, 32'hAAAA_0001);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(OP_MTLO, 32'h5555_0002, 32'd0, 1'b0, "", 32'd0, 32'd0, 0);
    checkOutput("mtlo_lo", LO, 32'h5555_0002);
    checkOutput("mtlo_hi", HI, 32'hAAAA_0001);
    applyStimulus(OP_RSVD, 32'hFFFF_FFFF, 32'h1, 1'b0, "", 32'd0, 32'd0, 0);
    checkOutput("rsvd_busy", {31'd0, busy}, 32'd0);
    checkOutput("rsvd_hi", HI, 32'hAAAA_0001);
    checkOutput("rsvd_lo", LO, 32'h5555_0002);

    // Reset two cycles into a div
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0, "", 32'd0, 32'd0, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_hi", HI, 32'd0);
    checkOutput("midrst_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    applyStimulus(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, "", 32'd0, 32'd0, 0);
    checkOutput("postrst_hi", HI, 32'h0000_1234);
    checkOutput("postrst_lo", LO, 32'd0);
    checkOutput("postrst_busy", {31'd0, busy}, 32'd0);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    waitIdle("mult_neg");
    applyStimulus(OP_MULTU, 32'hFFFF_FFFD, 32'd7, 1'b1, "multu_big", 32'h0000_0006, 32'hFFFF_FFEB, 5);
    waitIdle("multu_big");
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mult_minint", 32'd0, 32'h8000_0000, 5);
    waitIdle("mult_minint");
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
    waitIdle("multu_max");
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    waitIdle("div_neg");
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, "div_negneg", 32'hFFFF_FFFF, 32'h0000_0003, 10);
    waitIdle("div_negneg");
    applyStimulus(OP_DIVU, 32'd7, 32'd2, 1'b1, "divu", 32'd1, 32'd3, 10);
    waitIdle("divu");
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf", 32'd0, 32'h8000_0000, 10);
    waitIdle("div_ovf");
    applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b1, "div_zero", 32'd0, 32'h8000_0000, 10);
    waitIdle("div_zero");

    // Starts on busy cycle 2 (mtlo) and cycle 5 (completion edge, multu) must be dropped
    applyStimulus(OP_MULT, 32'h1234_5678, 32'h0000_0100, 1'b1, "intf_mult", 32'h0000_0012, 32'h3456_7800, 5);
    @(negedge clk);
    pulseStart(OP_MTLO, 32'h0000_DEAD, 32'd0);
    checkOutput("intf_lo_hold", LO, 32'h8000_0000);
    checkOutput("intf_hi_hold", HI, 32'd0);
    @(negedge clk);
    @(negedge clk);
    pulseStart(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle("intf_mult");

    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b1, "divu_stable", 32'd6, 32'd142, 10);
    for (int i = 0; i < 9; i++) begin
      A = $urandom;
      B = $urandom_range(1, 50);
      @(negedge clk);
    end
    A = 32'd0;
    B = 32'd0;
    waitIdle("divu_stable");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
